// File: rtl/apb_master_if.sv
// Command/response port and APB bus of the APB initiator, grouped as one bundle.
// "master" is the view of apb_master itself; "slave" is the view of whatever surrounds it.
interface apb_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic                  i_cmd_valid;
    logic                  o_cmd_ready;
    logic                  i_cmd_write;
    logic [ADDR_WIDTH-1:0] i_cmd_addr;
    logic [DATA_WIDTH-1:0] i_cmd_wdata;
    logic [STRB_WIDTH-1:0] i_cmd_strb;

    logic                  o_rsp_valid;
    logic                  i_rsp_ready;
    logic [DATA_WIDTH-1:0] o_rsp_rdata;
    logic                  o_rsp_err;
    logic                  o_rsp_timeout;

    logic                  o_psel;
    logic                  o_penable;
    logic                  o_pwrite;
    logic [ADDR_WIDTH-1:0] o_paddr;
    logic [DATA_WIDTH-1:0] o_pwdata;
    logic [STRB_WIDTH-1:0] o_pstrb;
    logic                  i_pready;
    logic                  i_pslverr;
    logic [DATA_WIDTH-1:0] i_prdata;

    modport master (
        input  i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_strb,
        output o_cmd_ready,
        output o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        input  i_rsp_ready,
        output o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
        input  i_pready, i_pslverr, i_prdata
    );

    modport slave (
        output i_cmd_valid, i_cmd_write, i_cmd_addr, i_cmd_wdata, i_cmd_strb,
        input  o_cmd_ready,
        input  o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
        output i_rsp_ready,
        input  o_psel, o_penable, o_pwrite, o_paddr, o_pwdata, o_pstrb,
        output i_pready, i_pslverr, i_prdata
    );
endinterface

// File: rtl/apb_master.sv
// APB3/APB4 initiator: one command in, one SETUP+ACCESS transfer out, one response back.
// Single outstanding transfer, optional ACCESS-phase timeout, fully registered bus outputs.
module apb_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input logic          i_clk,
    input logic          i_reset,
    apb_master_if.master bus
);
    localparam int STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int CNT_WIDTH   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_WIDTH-1:0] TO_LAST = TO_LAST_INT[CNT_WIDTH-1:0];

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t                state_q;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [STRB_WIDTH-1:0] pstrb_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_err_q;
    logic                  rsp_timeout_q;
    logic [CNT_WIDTH-1:0]  cnt_q;
    logic                  timeout_hit;

    // With TIMEOUT == 0 the counter exists but never triggers an abort.
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == TO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q       <= IDLE;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            pstrb_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.i_cmd_valid) begin
                        state_q   <= SETUP;
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        pwrite_q  <= bus.i_cmd_write;
                        paddr_q   <= bus.i_cmd_addr;
                        pwdata_q  <= bus.i_cmd_write ? bus.i_cmd_wdata : '0;
                        pstrb_q   <= bus.i_cmd_write ? bus.i_cmd_strb : '0;
                        cnt_q     <= '0;
                    end
                end
                SETUP: begin
                    state_q   <= ACCESS;
                    penable_q <= 1'b1;
                end
                ACCESS: begin
                    // A completing slave takes priority over a timeout in the same cycle.
                    if (bus.i_pready) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= (!pwrite_q && !bus.i_pslverr) ? bus.i_prdata : '0;
                        rsp_err_q     <= bus.i_pslverr;
                        rsp_timeout_q <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q       <= RESP;
                        psel_q        <= 1'b0;
                        penable_q     <= 1'b0;
                        rsp_valid_q   <= 1'b1;
                        rsp_rdata_q   <= '0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.o_cmd_ready   = (state_q == IDLE);
    assign bus.o_psel        = psel_q;
    assign bus.o_penable     = penable_q;
    assign bus.o_pwrite      = pwrite_q;
    assign bus.o_paddr       = paddr_q;
    assign bus.o_pwdata      = pwdata_q;
    assign bus.o_pstrb       = pstrb_q;
    assign bus.o_rsp_valid   = rsp_valid_q;
    assign bus.o_rsp_rdata   = rsp_rdata_q;
    assign bus.o_rsp_err     = rsp_err_q;
    assign bus.o_rsp_timeout = rsp_timeout_q;
endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: vector table of single transfers plus hand-written
// sequences for reset state, response backpressure and reset during ACCESS.
module tb_apb_master;
    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    apb_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        write;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int          waits;      // ACCESS cycles with pready=0 before completion
        logic        slverr;
        logic [31:0] prdata;
        logic        exp_timeout; // slave never answers; expect abort after waits cycles
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [31:0] exp_pwdata;
        logic [3:0]  exp_pstrb;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = v.write;
        bus.i_cmd_addr  = v.addr;
        bus.i_cmd_wdata = v.wdata;
        bus.i_cmd_strb  = v.strb;
        check({tag, ".cmd_ready_idle"}, 64'(bus.o_cmd_ready), 64'd1);
        @(negedge clk); // SETUP
        bus.i_cmd_valid = 1'b0;
        check({tag, ".setup_psel"}, 64'(bus.o_psel), 64'd1);
        check({tag, ".setup_penable"}, 64'(bus.o_penable), 64'd0);
        check({tag, ".pwrite"}, 64'(bus.o_pwrite), 64'(v.write));
        check({tag, ".paddr"}, 64'(bus.o_paddr), 64'(v.addr));
        check({tag, ".pwdata"}, 64'(bus.o_pwdata), 64'(v.exp_pwdata));
        check({tag, ".pstrb"}, 64'(bus.o_pstrb), 64'(v.exp_pstrb));
        check({tag, ".cmd_ready_busy"}, 64'(bus.o_cmd_ready), 64'd0);
        @(negedge clk); // first ACCESS cycle
        check({tag, ".access_psel"}, 64'(bus.o_psel), 64'd1);
        check({tag, ".access_penable"}, 64'(bus.o_penable), 64'd1);
        check({tag, ".access_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
        bus.i_pslverr = v.slverr;
        bus.i_prdata  = v.prdata;
        for (int k = 0; k < v.waits; k++) begin
            bus.i_pready = 1'b0;
            @(negedge clk);
        end
        if (!v.exp_timeout) begin
            check({tag, ".wait_penable"}, 64'(bus.o_penable), 64'd1);
            check({tag, ".wait_paddr"}, 64'(bus.o_paddr), 64'(v.addr));
            bus.i_pready = 1'b1;
            @(negedge clk);
            bus.i_pready = 1'b0;
        end
        bus.i_pslverr = 1'b0;
        bus.i_prdata  = '0;
        check({tag, ".rsp_valid"}, 64'(bus.o_rsp_valid), 64'd1);
        check({tag, ".rsp_psel"}, 64'(bus.o_psel), 64'd0);
        check({tag, ".rsp_penable"}, 64'(bus.o_penable), 64'd0);
        check({tag, ".rsp_rdata"}, 64'(bus.o_rsp_rdata), 64'(v.exp_rdata));
        check({tag, ".rsp_err"}, 64'(bus.o_rsp_err), 64'(v.exp_err));
        check({tag, ".rsp_timeout"}, 64'(bus.o_rsp_timeout), 64'(v.exp_timeout));
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        check({tag, ".done_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
        check({tag, ".done_cmd_ready"}, 64'(bus.o_cmd_ready), 64'd1);
        check({tag, ".idle_paddr_hold"}, 64'(bus.o_paddr), 64'(v.addr));
        $display("vec %0d: %s addr=0x%02h waits=%0d rdata=0x%08h err=%0d to=%0d",
                 idx, v.write ? "W" : "R", v.addr, v.waits,
                 bus.o_rsp_rdata, bus.o_rsp_err, bus.o_rsp_timeout);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        //            wr    addr   wdata         strb  wt  err   prdata        to    exp_rdata     e_err pwdata        pstrb
        vecs[0] = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0,  1'b0, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 32'hDEADBEEF, 4'hF};
        vecs[1] = '{1'b0, 8'h20, 32'h00000000, 4'h0, 3,  1'b0, 32'h12345678, 1'b0, 32'h12345678, 1'b0, 32'h00000000, 4'h0};
        vecs[2] = '{1'b0, 8'h24, 32'h00000000, 4'h0, 0,  1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 32'h00000000, 4'h0};
        vecs[3] = '{1'b0, 8'h30, 32'h00000000, 4'h0, 16, 1'b0, 32'h99999999, 1'b1, 32'h00000000, 1'b1, 32'h00000000, 4'h0};
        vecs[4] = '{1'b1, 8'h44, 32'hA5A5A5A5, 4'h5, 2,  1'b1, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 32'hA5A5A5A5, 4'h5};
        vecs[5] = '{1'b0, 8'hFF, 32'h00000000, 4'h0, 15, 1'b0, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 1'b0, 32'h00000000, 4'h0};
        vecs[6] = '{1'b0, 8'h08, 32'h11111111, 4'hF, 1,  1'b0, 32'h0BADC0DE, 1'b0, 32'h0BADC0DE, 1'b0, 32'h00000000, 4'h0};
        vecs[7] = '{1'b1, 8'h00, 32'hFFFFFFFF, 4'h0, 0,  1'b0, 32'h55555555, 1'b0, 32'h00000000, 1'b0, 32'hFFFFFFFF, 4'h0};

        rst             = 1'b1;
        bus.i_cmd_valid = 1'b0;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = '0;
        bus.i_cmd_wdata = '0;
        bus.i_cmd_strb  = '0;
        bus.i_rsp_ready = 1'b0;
        bus.i_pready    = 1'b0;
        bus.i_pslverr   = 1'b0;
        bus.i_prdata    = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset.cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("reset.psel", 64'(bus.o_psel), 64'd0);
        check("reset.penable", 64'(bus.o_penable), 64'd0);
        check("reset.pwrite", 64'(bus.o_pwrite), 64'd0);
        check("reset.paddr", 64'(bus.o_paddr), 64'd0);
        check("reset.pwdata", 64'(bus.o_pwdata), 64'd0);
        check("reset.pstrb", 64'(bus.o_pstrb), 64'd0);
        check("reset.rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("reset.rsp_rdata", 64'(bus.o_rsp_rdata), 64'd0);
        check("reset.rsp_err", 64'(bus.o_rsp_err), 64'd0);
        check("reset.rsp_timeout", 64'(bus.o_rsp_timeout), 64'd0);
        $display("reset: state checked");

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Backpressure: hold the response for 5 cycles while a new command waits.
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = 8'h50;
        @(negedge clk); // SETUP
        bus.i_cmd_valid = 1'b0;
        @(negedge clk); // ACCESS
        bus.i_pready = 1'b1;
        bus.i_prdata = 32'h87654321;
        @(negedge clk); // RESP
        bus.i_pready    = 1'b0;
        bus.i_prdata    = '0;
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b1;
        bus.i_cmd_addr  = 8'h60;
        bus.i_cmd_wdata = 32'h0000ABCD;
        bus.i_cmd_strb  = 4'h3;
        for (int k = 0; k < 5; k++) begin
            check("bp.rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
            check("bp.rsp_rdata", 64'(bus.o_rsp_rdata), 64'h87654321);
            check("bp.cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
            check("bp.psel", 64'(bus.o_psel), 64'd0);
            @(negedge clk);
        end
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        check("bp.release_rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("bp.release_cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
        check("bp.release_psel", 64'(bus.o_psel), 64'd0);
        @(negedge clk); // pending write accepted at the previous edge
        bus.i_cmd_valid = 1'b0;
        check("bp.next_psel", 64'(bus.o_psel), 64'd1);
        check("bp.next_paddr", 64'(bus.o_paddr), 64'h60);
        check("bp.next_pwdata", 64'(bus.o_pwdata), 64'h0000ABCD);
        @(negedge clk); // ACCESS
        bus.i_pready = 1'b1;
        @(negedge clk);
        bus.i_pready = 1'b0;
        check("bp.next_rsp_valid", 64'(bus.o_rsp_valid), 64'd1);
        check("bp.next_rsp_err", 64'(bus.o_rsp_err), 64'd0);
        bus.i_rsp_ready = 1'b1;
        @(negedge clk);
        bus.i_rsp_ready = 1'b0;
        $display("backpressure: 5-cycle hold then queued write");

        // Reset asserted for one cycle in the middle of ACCESS.
        @(negedge clk);
        bus.i_cmd_valid = 1'b1;
        bus.i_cmd_write = 1'b0;
        bus.i_cmd_addr  = 8'h70;
        @(negedge clk); // SETUP
        bus.i_cmd_valid = 1'b0;
        @(negedge clk); // ACCESS 1
        bus.i_pready = 1'b0;
        @(negedge clk); // ACCESS 2
        check("rst_access.penable_before", 64'(bus.o_penable), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_access.psel", 64'(bus.o_psel), 64'd0);
        check("rst_access.penable", 64'(bus.o_penable), 64'd0);
        check("rst_access.rsp_valid", 64'(bus.o_rsp_valid), 64'd0);
        check("rst_access.cmd_ready", 64'(bus.o_cmd_ready), 64'd1);
        bus.i_pready = 1'b1;
        bus.i_prdata = 32'h13572468;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_access.no_rsp", 64'(bus.o_rsp_valid), 64'd0);
            check("rst_access.no_psel", 64'(bus.o_psel), 64'd0);
        end
        bus.i_pready = 1'b0;
        bus.i_prdata = '0;
        $display("reset in ACCESS: transfer discarded");

        run_vec(vecs[1], 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
